gaussian_convolve: RTL and testbench
====================================

# gaussian_convolve

Sequential normalised-convolution stage that consumes the Gaussian kernel produced by the kernel-initialisation block and applies it to square pixel windows from the line-buffer/window stage. It computes one output pixel per window. Each window takes one multiply-accumulate per tap, then a rounded division by the kernel sum. It sits between the window generator and the FAST corner-detection stage; both sides use valid/ready handshakes.

## Interface
- MAX_KERNAL, 7: window and kernel array dimension; odd, 3..15.
- DIV_W, 16: divisor (kernel sum) width in bits.
- ACC_W, 24: accumulator and dividend width in bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- kernel_load  in  1  single-cycle pulse from the kernel builder's done output; samples kernel, kernel_size and sum on that edge.
- kernel_size  in  $clog2(MAX_KERNAL)  active kernel dimension k.
- kernel  in  [MAX_KERNAL][MAX_KERNAL][8]  unsigned weights; taps live at kernel[i][j], i,j in 0..k-1.
- sum  in  64  sum of the k×k active weights.
- kernel_ready  out  1  a valid kernel is active.
- kernel_err  out  1  one-cycle pulse when a load is rejected.
- win_valid  in  1  window available.
- win_ready  out  1  block accepts a window.
- window  in  [MAX_KERNAL][MAX_KERNAL][8]  unsigned pixels.
- pix_valid  out  1  result available.
- pix_ready  in  1  downstream accepts the result.
- pix_out  out  8  filtered pixel.

## Operation
- Load validation: a load is accepted only if all of the following hold:
  - k is odd;
  - 1 ≤ k ≤ MAX_KERNAL;
  - sum ≠ 0;
  - sum < 2^DIV_W.
- Rejected load:
  - kernel_err pulses on the next cycle;
  - kernel_ready drops to 0;
  - the previous kernel is discarded.
- Accepted load:
  - kernel, k and sum[DIV_W-1:0] are captured into shadow registers on the kernel_load edge.
  - The shadow is copied to the active set on the first cycle the FSM is in IDLE. If the FSM is already IDLE, the copy happens on the next edge.
  - kernel_ready becomes 1 when the copy happens.
  - While a load is pending, win_ready is 0.
  - A second load before the copy overwrites the shadow; the last load wins.
- FSM states: IDLE, MAC, DIV, OUT.
- IDLE:
  - win_ready = kernel_ready and no load pending.
  - On win_valid && win_ready, latch the window, clear the accumulator and tap counter, and go to MAC.
- MAC:
  - Taps are taken in row-major order, one per cycle, for k² cycles.
  - Each cycle: acc += kernel[i][j] × window[off+i][off+j], where off = (MAX_KERNAL−k)/2, so the kernel is centred in the window.
  - After the last tap, load dividend = acc + (sum>>1) (round half up) and go to DIV.
- DIV:
  - Restoring division, one quotient bit per cycle, ACC_W cycles.
  - Quotient = floor(dividend / sum).
  - Then go to OUT.
- OUT:
  - pix_valid = 1.
  - pix_out = quotient saturated to 255 (quotient > 255 gives 255).
  - Held stable until pix_ready; on the handshake edge, go to IDLE.
- Width rules:
  - Products are 16 bits.
  - The accumulator is ACC_W bits. The maximum, MAX_KERNAL² × 255² + 2^(DIV_W−1), fits in ACC_W bits for the defaults.

## Timing
- Reset values (synchronous, after one rst edge):
  - FSM = IDLE;
  - kernel_ready = 0, kernel_err = 0;
  - win_ready = 0, pix_valid = 0, pix_out = 0;
  - accumulator, tap counter and divider cleared;
  - no load pending.
- rst during MAC, DIV or OUT: all in-flight work and any pending load are dropped. The block returns to the reset state on the next edge.
- Latency: for a window accepted on edge E, pix_valid rises after edge E + k² + ACC_W. With defaults and k=3, that is E+33.
- Throughput: at most one window per k² + ACC_W + 1 cycles. win_ready is 0 in MAC, DIV and OUT.
- A load pulse on the same edge as a window handshake:
  - the window proceeds with the old kernel;
  - the new kernel becomes active on return to IDLE.
- pix_valid never drops without pix_ready; pix_out does not change while pix_valid is high.

## Test plan
- Identity kernel:
  - Stimulus: load k=1, kernel[0][0]=1, sum=1; window[3][3]=200, all other pixels 0.
  - Required: pix_out=200, pix_valid exactly 25 edges after accept.
- Box 3×3:
  - Stimulus: k=3, all weights 1, sum=9; centre 3×3 pixels 0..8 (total 36).
  - Required: pix_out=(36+4)/9=4 at accept+33.
- Saturation:
  - Stimulus: k=3, all weights 1, sum=1; window all 255.
  - Required: pix_out=255.
- Backpressure:
  - Stimulus: hold pix_ready=0 for 5 cycles in OUT.
  - Required: pix_valid and pix_out stable and win_ready=0 throughout; a second window is accepted only after the pix handshake.
- Invalid loads:
  - Stimulus: k=2, then k=3 with sum=0, then k=3 with sum=2^16.
  - Required: each pulses kernel_err; kernel_ready=0 and win_ready=0 afterwards.
- Reload and reset:
  - Stimulus: a load pulse during MAC.
  - Required: the current result uses the old kernel; the next window uses the new one.
  - Stimulus: rst asserted mid-DIV.
  - Required: all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/gaussian_convolve.sv
// Normalised k x k convolution: serial MAC over the centred window taps,
// then a restoring divide by the kernel sum with round-half-up and saturation.
module gaussian_convolve #(
  parameter int MAX_KERNAL = 7,
  parameter int DIV_W      = 16,
  parameter int ACC_W      = 24
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       kernel_load,
  input  logic [$clog2(MAX_KERNAL)-1:0]              kernel_size,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel,
  input  logic [63:0]                                sum,
  output logic                                       kernel_ready,
  output logic                                       kernel_err,
  input  logic                                       win_valid,
  output logic                                       win_ready,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] window,
  output logic                                       pix_valid,
  input  logic                                       pix_ready,
  output logic [7:0]                                 pix_out
);

  localparam int KS_W = $clog2(MAX_KERNAL);
  localparam int CW   = $clog2(ACC_W + 1);
  localparam logic [KS_W-1:0] MAXK = KS_W'(MAX_KERNAL);

  typedef logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] grid_t;
  typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_e;

  state_e            state_q, state_d;
  grid_t             kern_sh_q, kern_sh_d, kern_act_q, kern_act_d;
  grid_t             win_q, win_d;
  logic [KS_W-1:0]   k_sh_q, k_sh_d, k_act_q, k_act_d;
  logic [DIV_W-1:0]  sum_sh_q, sum_sh_d, sum_act_q, sum_act_d;
  logic              pend_q, pend_d, kready_q, kready_d, err_q, err_d;
  logic [KS_W-1:0]   row_q, row_d, col_q, col_d;
  logic [ACC_W-1:0]  acc_q, acc_d, quo_q, quo_d;
  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        pix_q, pix_d;

  logic              load_ok, last_tap, ge;
  logic [KS_W-1:0]   off, km1, wr, wc;
  logic [15:0]       prod;
  logic [ACC_W-1:0]  mac_sum;
  logic [DIV_W:0]    shl;
  logic [DIV_W-1:0]  diff;

  assign win_ready    = (state_q == IDLE) && kready_q && !pend_q;
  assign pix_valid    = (state_q == OUT);
  assign pix_out      = pix_q;
  assign kernel_ready = kready_q;
  assign kernel_err   = err_q;

  always_comb begin
    load_ok = kernel_size[0] && (kernel_size <= MAXK) &&
              (sum != 64'd0) && (sum[63:DIV_W] == '0);
    off      = (MAXK - k_act_q) >> 1;
    km1      = k_act_q - KS_W'(1);
    wr       = off + row_q;
    wc       = off + col_q;
    prod     = {8'd0, kern_act_q[row_q][col_q]} * {8'd0, win_q[wr][wc]};
    mac_sum  = acc_q + {{(ACC_W-16){1'b0}}, prod};
    last_tap = (row_q == km1) && (col_q == km1);
    shl      = {rem_q, quo_q[ACC_W-1]};
    ge       = shl[DIV_W] || (shl[DIV_W-1:0] >= sum_act_q);
    diff     = shl[DIV_W-1:0] - sum_act_q;
  end

  always_comb begin
    state_d    = state_q;
    kern_sh_d  = kern_sh_q;
    kern_act_d = kern_act_q;
    win_d      = win_q;
    k_sh_d     = k_sh_q;
    k_act_d    = k_act_q;
    sum_sh_d   = sum_sh_q;
    sum_act_d  = sum_act_q;
    pend_d     = pend_q;
    kready_d   = kready_q;
    err_d      = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;

    // A fresh load takes priority; the shadow copy then waits one more edge.
    if (kernel_load) begin
      if (load_ok) begin
        kern_sh_d = kernel;
        k_sh_d    = kernel_size;
        sum_sh_d  = sum[DIV_W-1:0];
        pend_d    = 1'b1;
      end else begin
        pend_d   = 1'b0;
        kready_d = 1'b0;
        err_d    = 1'b1;
      end
    end else if (pend_q && state_q == IDLE) begin
      kern_act_d = kern_sh_q;
      k_act_d    = k_sh_q;
      sum_act_d  = sum_sh_q;
      kready_d   = 1'b1;
      pend_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (win_valid && win_ready) begin
          win_d   = window;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = mac_sum;
        if (last_tap) begin
          quo_d   = mac_sum +
                    {{(ACC_W-DIV_W+1){1'b0}}, sum_act_q[DIV_W-1:1]};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end else if (col_q == km1) begin
          col_d = '0;
          row_d = row_q + KS_W'(1);
        end else begin
          col_d = col_q + KS_W'(1);
        end
      end
      DIV: begin
        rem_d = ge ? diff : shl[DIV_W-1:0];
        quo_d = {quo_q[ACC_W-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_W - 1)) begin
          pix_d   = (quo_d > ACC_W'(255)) ? 8'hFF : quo_d[7:0];
          state_d = OUT;
        end
      end
      OUT: begin
        if (pix_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kern_sh_q  <= '0;
      kern_act_q <= '0;
      win_q      <= '0;
      k_sh_q     <= '0;
      k_act_q    <= '0;
      sum_sh_q   <= '0;
      sum_act_q  <= '0;
      pend_q     <= 1'b0;
      kready_q   <= 1'b0;
      err_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      kern_sh_q  <= kern_sh_d;
      kern_act_q <= kern_act_d;
      win_q      <= win_d;
      k_sh_q     <= k_sh_d;
      k_act_q    <= k_act_d;
      sum_sh_q   <= sum_sh_d;
      sum_act_q  <= sum_act_d;
      pend_q     <= pend_d;
      kready_q   <= kready_d;
      err_q      <= err_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
    end
  end

endmodule

// File: tb/tb_gaussian_convolve.sv
// Directed bench for gaussian_convolve: hand-computed pixels, latency,
// backpressure, load rejection, reload during MAC and reset mid-divide.
module tb_gaussian_convolve;

  typedef logic [6:0][6:0][7:0] grid_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        kernel_load;
  logic [2:0]  kernel_size;
  grid_t       kernel;
  logic [63:0] sum;
  logic        kernel_ready, kernel_err;
  logic        win_valid, win_ready;
  grid_t       window;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_out;

  int checks = 0;
  int errors = 0;

  gaussian_convolve dut (
    .clk(clk), .rst(rst),
    .kernel_load(kernel_load), .kernel_size(kernel_size),
    .kernel(kernel), .sum(sum),
    .kernel_ready(kernel_ready), .kernel_err(kernel_err),
    .win_valid(win_valid), .win_ready(win_ready), .window(window),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_out(pix_out)
  );

  always #5 clk = ~clk;

  task automatic load_kernel(input int k, input logic [7:0] w,
                             input logic [63:0] s);
    @(negedge clk);
    kernel = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++) kernel[i][j] = w;
    kernel_size = 3'(k);
    sum = s;
    kernel_load = 1'b1;
    @(posedge clk); #1;
    kernel_load = 1'b0;
  endtask

  task automatic accept_window(input grid_t w);
    int n;
    n = 0;
    @(negedge clk);
    window = w;
    win_valid = 1'b1;
    while (!win_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (win_ready !== 1'b1) begin
      $display("FAIL accept_timeout: win_ready=%b required 1", win_ready);
      errors++;
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic wait_pix(output int n);
    n = 0;
    while (!pix_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pix_handshake();
    @(negedge clk);
    pix_ready = 1'b1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
  endtask

  function automatic grid_t box_window();
    grid_t g;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) g[i][j] = 8'd100;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) g[2+i][2+j] = 8'(3*i + j);
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (kernel_ready !== 1'b0) begin
      $display("FAIL reset_kready: got %b required 0", kernel_ready); errors++;
    end
    if (kernel_err !== 1'b0) begin
      $display("FAIL reset_kerr: got %b required 0", kernel_err); errors++;
    end
    if (win_ready !== 1'b0) begin
      $display("FAIL reset_win_ready: got %b required 0", win_ready); errors++;
    end
    if (pix_valid !== 1'b0) begin
      $display("FAIL reset_pix_valid: got %b required 0", pix_valid); errors++;
    end
    if (pix_out !== 8'd0) begin
      $display("FAIL reset_pix_out: got %0d required 0", pix_out); errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    grid_t g;
    int n;
    load_kernel(1, 8'd1, 64'd1);
    @(posedge clk); #1;
    checks++;
    if (kernel_ready !== 1'b1) begin
      $display("FAIL ident_kready: got %b required 1", kernel_ready); errors++;
    end
    g = '0;
    g[3][3] = 8'd200;
    accept_window(g);
    wait_pix(n);
    checks += 2;
    if (n !== 25) begin
      $display("FAIL ident_latency: got %0d required 25", n); errors++;
    end
    if (pix_out !== 8'd200) begin
      $display("FAIL ident_pix: got %0d required 200", pix_out); errors++;
    end
    pix_handshake();
  endtask

  task automatic test_box();
    int n;
    load_kernel(3, 8'd1, 64'd9);
    @(posedge clk); #1;
    accept_window(box_window());
    wait_pix(n);
    checks += 2;
    if (n !== 33) begin
      $display("FAIL box_latency: got %0d required 33", n); errors++;
    end
    if (pix_out !== 8'd4) begin
      $display("FAIL box_pix: got %0d required 4", pix_out); errors++;
    end
    pix_handshake();
  endtask

  task automatic test_saturation();
    grid_t g;
    int n;
    load_kernel(3, 8'd1, 64'd1);
    @(posedge clk); #1;
    g = '1;
    accept_window(g);
    wait_pix(n);
    checks += 2;
    if (n !== 33) begin
      $display("FAIL sat_latency: got %0d required 33", n); errors++;
    end
    if (pix_out !== 8'd255) begin
      $display("FAIL sat_pix: got %0d required 255", pix_out); errors++;
    end
    pix_handshake();
  endtask

  task automatic test_backpressure();
    grid_t g;
    int n;
    load_kernel(3, 8'd1, 64'd9);
    @(posedge clk); #1;
    accept_window(box_window());
    wait_pix(n);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) g[i][j] = 8'd90;
    window = g;
    win_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 3;
      if (pix_valid !== 1'b1) begin
        $display("FAIL bp_valid c%0d: got %b required 1", c, pix_valid); errors++;
      end
      if (pix_out !== 8'd4) begin
        $display("FAIL bp_pix c%0d: got %0d required 4", c, pix_out); errors++;
      end
      if (win_ready !== 1'b0) begin
        $display("FAIL bp_win_ready c%0d: got %b required 0", c, win_ready); errors++;
      end
    end
    pix_handshake();
    checks++;
    if (win_ready !== 1'b1) begin
      $display("FAIL bp_reaccept: win_ready=%b required 1", win_ready); errors++;
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
    wait_pix(n);
    checks += 2;
    if (n !== 33) begin
      $display("FAIL bp2_latency: got %0d required 33", n); errors++;
    end
    if (pix_out !== 8'd90) begin
      $display("FAIL bp2_pix: got %0d required 90", pix_out); errors++;
    end
    pix_handshake();
  endtask

  task automatic test_invalid_loads();
    int ks[3];
    logic [63:0] ss[3];
    ks = '{2, 3, 3};
    ss = '{64'd4, 64'd0, 64'h1_0000};
    for (int t = 0; t < 3; t++) begin
      load_kernel(ks[t], 8'd1, ss[t]);
      checks += 3;
      if (kernel_err !== 1'b1) begin
        $display("FAIL inv_err t%0d: got %b required 1", t, kernel_err); errors++;
      end
      if (kernel_ready !== 1'b0) begin
        $display("FAIL inv_kready t%0d: got %b required 0", t, kernel_ready); errors++;
      end
      if (win_ready !== 1'b0) begin
        $display("FAIL inv_win_ready t%0d: got %b required 0", t, win_ready); errors++;
      end
      @(posedge clk); #1;
      checks++;
      if (kernel_err !== 1'b0) begin
        $display("FAIL inv_err_pulse t%0d: got %b required 0", t, kernel_err); errors++;
      end
    end
  endtask

  task automatic test_reload();
    grid_t g;
    int n;
    load_kernel(3, 8'd1, 64'd9);
    @(posedge clk); #1;
    g = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) g[2+i][2+j] = 8'd9;
    g[3][3] = 8'd90;
    accept_window(g);
    load_kernel(1, 8'd1, 64'd1);
    wait_pix(n);
    checks++;
    if (pix_out !== 8'd18) begin
      $display("FAIL reload_old_kernel: got %0d required 18", pix_out); errors++;
    end
    pix_handshake();
    g = '0;
    g[3][3] = 8'd77;
    accept_window(g);
    wait_pix(n);
    checks += 2;
    if (pix_out !== 8'd77) begin
      $display("FAIL reload_new_kernel: got %0d required 77", pix_out); errors++;
    end
    if (n !== 25) begin
      $display("FAIL reload_latency: got %0d required 25", n); errors++;
    end
    pix_handshake();
  endtask

  task automatic test_reset_mid_div();
    load_kernel(3, 8'd1, 64'd9);
    @(posedge clk); #1;
    accept_window(box_window());
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 5;
    if (kernel_ready !== 1'b0) begin
      $display("FAIL rstdiv_kready: got %b required 0", kernel_ready); errors++;
    end
    if (kernel_err !== 1'b0) begin
      $display("FAIL rstdiv_kerr: got %b required 0", kernel_err); errors++;
    end
    if (win_ready !== 1'b0) begin
      $display("FAIL rstdiv_win_ready: got %b required 0", win_ready); errors++;
    end
    if (pix_valid !== 1'b0) begin
      $display("FAIL rstdiv_pix_valid: got %b required 0", pix_valid); errors++;
    end
    if (pix_out !== 8'd0) begin
      $display("FAIL rstdiv_pix_out: got %0d required 0", pix_out); errors++;
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (pix_valid !== 1'b0) begin
      $display("FAIL rstdiv_no_result: got %b required 0", pix_valid); errors++;
    end
  endtask

  initial begin
    rst = 1'b1;
    kernel_load = 1'b0;
    kernel_size = '0;
    kernel = '0;
    sum = '0;
    win_valid = 1'b0;
    window = '0;
    pix_ready = 1'b0;
    test_reset();
    test_identity();
    test_box();
    test_saturation();
    test_backpressure();
    test_invalid_loads();
    test_reload();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
